// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour types and motion FSM encoding.
package vga_pkg;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned COORD_W  = 12;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb12_t;

   // Index 0..3 = F00, 0F0, 00F, FF0 (element 0 is the rightmost slice)
   localparam rgb12_t [3:0] PALETTE = {rgb12_t'(12'hFF0), rgb12_t'(12'h00F),
                                       rgb12_t'(12'h0F0), rgb12_t'(12'hF00)};
   localparam rgb12_t BG_COLOUR     = rgb12_t'(12'h003);
   localparam rgb12_t BORDER_COLOUR = rgb12_t'(12'hFFF);

   typedef enum logic [1:0] {
      WAIT_FRAME,
      UPDATE_X,
      UPDATE_Y,
      DONE
   } motion_state_t;

endpackage

// File: rtl/box_motion.sv
// Once-per-frame box motion: bounce position, directions, palette index, frame tick.
module box_motion
   import vga_pkg::*;
#(
   parameter int unsigned BOX_W  = 32,
   parameter int unsigned BOX_H  = 32,
   parameter int unsigned SPEED  = 2,
   parameter int unsigned INIT_X = 100,
   parameter int unsigned INIT_Y = 60
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      vsync,
   input  logic                      run,
   output logic signed [COORD_W-1:0] box_x,
   output logic signed [COORD_W-1:0] box_y,
   output logic [1:0]                colour_idx,
   output logic                      frame_tick
);

   localparam logic signed [COORD_W-1:0] ZERO_S  = COORD_W'(0);
   localparam logic signed [COORD_W-1:0] SPEED_S = COORD_W'(SPEED);
   localparam logic signed [COORD_W-1:0] X_MAX_S = COORD_W'(H_ACTIVE - BOX_W);
   localparam logic signed [COORD_W-1:0] Y_MAX_S = COORD_W'(V_ACTIVE - BOX_H);
   localparam logic signed [COORD_W-1:0] INIT_X_S = COORD_W'(INIT_X);
   localparam logic signed [COORD_W-1:0] INIT_Y_S = COORD_W'(INIT_Y);

   motion_state_t             state_q, state_d;
   logic signed [COORD_W-1:0] box_x_q, box_x_d, box_y_q, box_y_d;
   logic signed [COORD_W-1:0] nx, ny;
   logic                      dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
   logic [1:0]                colour_q, colour_d;
   logic                      vs_prev_q, vs_prev_d;
   logic                      frame_edge_q, frame_edge_d;
   logic                      tick_q, tick_d;

   // Next-state, bounce arithmetic and vsync falling-edge detect
   always_comb begin
      state_d      = state_q;
      box_x_d      = box_x_q;
      box_y_d      = box_y_q;
      dx_neg_d     = dx_neg_q;
      dy_neg_d     = dy_neg_q;
      colour_d     = colour_q;
      vs_prev_d    = vsync;
      frame_edge_d = vs_prev_q & ~vsync;
      nx = dx_neg_q ? (box_x_q - SPEED_S) : (box_x_q + SPEED_S);
      ny = dy_neg_q ? (box_y_q - SPEED_S) : (box_y_q + SPEED_S);

      unique case (state_q)
         WAIT_FRAME: if (frame_edge_q) state_d = UPDATE_X;
         UPDATE_X: begin
            state_d = UPDATE_Y;
            if (run) begin
               if (nx <= ZERO_S) begin
                  box_x_d  = ZERO_S;
                  dx_neg_d = 1'b0;
                  colour_d = colour_q + 2'd1;
               end else if (nx >= X_MAX_S) begin
                  box_x_d  = X_MAX_S;
                  dx_neg_d = 1'b1;
                  colour_d = colour_q + 2'd1;
               end else begin
                  box_x_d = nx;
               end
            end
         end
         UPDATE_Y: begin
            state_d = DONE;
            if (run) begin
               if (ny <= ZERO_S) begin
                  box_y_d  = ZERO_S;
                  dy_neg_d = 1'b0;
                  colour_d = colour_q + 2'd1;
               end else if (ny >= Y_MAX_S) begin
                  box_y_d  = Y_MAX_S;
                  dy_neg_d = 1'b1;
                  colour_d = colour_q + 2'd1;
               end else begin
                  box_y_d = ny;
               end
            end
         end
         DONE:    state_d = WAIT_FRAME;
         default: state_d = WAIT_FRAME;
      endcase

      tick_d = (state_d == DONE);
   end

   // State and motion registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= WAIT_FRAME;
         box_x_q      <= INIT_X_S;
         box_y_q      <= INIT_Y_S;
         dx_neg_q     <= 1'b0;
         dy_neg_q     <= 1'b0;
         colour_q     <= 2'd0;
         vs_prev_q    <= 1'b1;
         frame_edge_q <= 1'b0;
         tick_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         box_x_q      <= box_x_d;
         box_y_q      <= box_y_d;
         dx_neg_q     <= dx_neg_d;
         dy_neg_q     <= dy_neg_d;
         colour_q     <= colour_d;
         vs_prev_q    <= vs_prev_d;
         frame_edge_q <= frame_edge_d;
         tick_q       <= tick_d;
      end
   end

   assign box_x      = box_x_q;
   assign box_y      = box_y_q;
   assign colour_idx = colour_q;
   assign frame_tick = tick_q;

endmodule

// File: rtl/bounce_box_renderer.sv
// Two-stage pixel pipeline drawing a bouncing box inside a white screen border.
module bounce_box_renderer
   import vga_pkg::*;
#(
   parameter int unsigned BOX_W  = 32,
   parameter int unsigned BOX_H  = 32,
   parameter int unsigned SPEED  = 2,
   parameter int unsigned INIT_X = 100,
   parameter int unsigned INIT_Y = 60
) (
   input  logic               clk,
   input  logic               reset,
   input  logic signed [31:0] x,
   input  logic signed [31:0] y,
   input  logic               enable,
   input  logic               hsync,
   input  logic               vsync,
   input  logic               run,
   output logic [3:0]         vga_r,
   output logic [3:0]         vga_g,
   output logic [3:0]         vga_b,
   output logic               vga_hs,
   output logic               vga_vs,
   output logic               frame_tick
);

   localparam int H_LIM   = int'(H_ACTIVE);
   localparam int V_LIM   = int'(V_ACTIVE);
   localparam int BOX_W_I = int'(BOX_W);
   localparam int BOX_H_I = int'(BOX_H);

   logic signed [COORD_W-1:0] box_x, box_y;
   logic [1:0]                colour_idx;
   logic signed [31:0]        bx_ext, by_ext;

   logic       active_q, active_d, border_q, border_d, inside_q, inside_d;
   logic       hs1_q, hs1_d, vs1_q, vs1_d, hs2_q, hs2_d, vs2_q, vs2_d;
   logic [1:0] col1_q, col1_d;
   rgb12_t     rgb_q, rgb_d;

   box_motion #(
      .BOX_W (BOX_W),
      .BOX_H (BOX_H),
      .SPEED (SPEED),
      .INIT_X(INIT_X),
      .INIT_Y(INIT_Y)
   ) u_motion (
      .clk       (clk),
      .reset     (reset),
      .vsync     (vsync),
      .run       (run),
      .box_x     (box_x),
      .box_y     (box_y),
      .colour_idx(colour_idx),
      .frame_tick(frame_tick)
   );

   // Stage 1: classify pixel against screen and current box position
   always_comb begin
      bx_ext   = 32'(box_x);
      by_ext   = 32'(box_y);
      active_d = enable && (x >= 0) && (x < H_LIM) && (y >= 0) && (y < V_LIM);
      border_d = active_d && ((x == 0) || (x == H_LIM - 1) ||
                              (y == 0) || (y == V_LIM - 1));
      inside_d = active_d && (x >= bx_ext) && (x < bx_ext + BOX_W_I) &&
                             (y >= by_ext) && (y < by_ext + BOX_H_I);
      col1_d   = colour_idx;
      hs1_d    = hsync;
      vs1_d    = vsync;
   end

   // Stage 2: colour select by priority blank > border > box > background
   always_comb begin
      hs2_d = hs1_q;
      vs2_d = vs1_q;
      if (!active_q)     rgb_d = rgb12_t'(12'h000);
      else if (border_q) rgb_d = BORDER_COLOUR;
      else if (inside_q) rgb_d = PALETTE[col1_q];
      else               rgb_d = BG_COLOUR;
   end

   // Pipeline registers; sync bits reset high (inactive)
   always_ff @(posedge clk) begin
      if (!reset) begin
         active_q <= 1'b0;
         border_q <= 1'b0;
         inside_q <= 1'b0;
         col1_q   <= 2'd0;
         hs1_q    <= 1'b1;
         vs1_q    <= 1'b1;
         hs2_q    <= 1'b1;
         vs2_q    <= 1'b1;
         rgb_q    <= rgb12_t'(12'h000);
      end else begin
         active_q <= active_d;
         border_q <= border_d;
         inside_q <= inside_d;
         col1_q   <= col1_d;
         hs1_q    <= hs1_d;
         vs1_q    <= vs1_d;
         hs2_q    <= hs2_d;
         vs2_q    <= vs2_d;
         rgb_q    <= rgb_d;
      end
   end

   assign vga_r  = rgb_q.r;
   assign vga_g  = rgb_q.g;
   assign vga_b  = rgb_q.b;
   assign vga_hs = hs2_q;
   assign vga_vs = vs2_q;

endmodule

// File: tb/tb_bounce_box_renderer.sv
// Randomised bench for bounce_box_renderer against a frame-level behavioural model.
module tb_bounce_box_renderer;

   localparam int N = 12000;

   logic               clk;
   logic               reset;
   logic signed [31:0] x, y;
   logic               enable, hsync, vsync, run;
   logic [3:0]         vga_r, vga_g, vga_b;
   logic               vga_hs, vga_vs, frame_tick;

   bounce_box_renderer dut (
      .clk(clk), .reset(reset), .x(x), .y(y), .enable(enable),
      .hsync(hsync), .vsync(vsync), .run(run),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_tick(frame_tick)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   // Input history indexed by the posedge number that samples it
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit        rst_a [N];
   bit        en_a  [N];
   int        x_a   [N];
   int        y_a   [N];
   bit        hs_a  [N];
   bit        vs_a  [N];
   bit        run_a [N];
   bit        pin_v [N];
   bit [11:0] pin_rgb [N];
   bit        tpin_v [N];

   int n_pass = 0;
   int n_tot  = 0;

   // Model state: box position, direction (+1/-1) and palette index
   int mbx, mby, mdx, mdy, mci;
   int pal [4] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0};

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
   endtask

   function automatic int model_pix(input int k);
      int px, py;
      px = x_a[k];
      py = y_a[k];
      if (!en_a[k] || px < 0 || px >= 640 || py < 0 || py >= 480) return 12'h000;
      if (px == 0 || px == 639 || py == 0 || py == 479) return 12'hFFF;
      if (px >= mbx && px < mbx + 32 && py >= mby && py < mby + 32) return pal[mci];
      return 12'h003;
   endfunction

   function automatic bit edge_at(input int k);
      if (k < 1) return 1'b0;
      if (!rst_a[k] || vs_a[k]) return 1'b0;
      if (!rst_a[k-1]) return 1'b1;
      return vs_a[k-1];
   endfunction

   task automatic model_step(input int k);
      int nx, ny;
      if (!rst_a[k]) begin
         mbx = 100; mby = 60; mdx = 1; mdy = 1; mci = 0;
      end else if (edge_at(k) && run_a[k]) begin
         nx = mbx + mdx * 2;
         if (nx <= 0)        begin mbx = 0;   mdx = 1;  mci = (mci + 1) % 4; end
         else if (nx >= 608) begin mbx = 608; mdx = -1; mci = (mci + 1) % 4; end
         else mbx = nx;
         ny = mby + mdy * 2;
         if (ny <= 0)        begin mby = 0;   mdy = 1;  mci = (mci + 1) % 4; end
         else if (ny >= 448) begin mby = 448; mdy = -1; mci = (mci + 1) % 4; end
         else mby = ny;
      end
   endtask

   // Compare process: outputs after posedge p reflect pixel p-1
   always @(negedge clk) begin
      int p, k, e_rgb, e_hs, e_vs, got;
      bit e_tick;
      p = cyc;
      if (p >= 2 && p < N) begin
         k = p - 1;
         if (!rst_a[p] || !rst_a[k]) begin
            e_rgb = 0; e_hs = 1; e_vs = 1;
         end else begin
            e_rgb = model_pix(k); e_hs = int'(hs_a[k]); e_vs = int'(vs_a[k]);
         end
         got = int'({vga_r, vga_g, vga_b});
         chk("rgb", got, e_rgb);
         chk("vga_hs", int'(vga_hs), e_hs);
         chk("vga_vs", int'(vga_vs), e_vs);
         if (pin_v[k]) chk("rgb_literal", got, int'(pin_rgb[k]));
         model_step(k);
         e_tick = (p >= 4) && edge_at(p - 3) && rst_a[p-2] && rst_a[p-1] && rst_a[p];
         chk("frame_tick", int'(frame_tick), int'(e_tick));
         if (tpin_v[p]) chk("tick_literal", int'(frame_tick), 1);
      end
   end

   task automatic drv(input bit r, input bit e, input int xi, input int yi,
                      input bit h, input bit v, input bit rn, output int k);
      @(posedge clk);
      #2;
      k = cyc + 1;
      if (k >= N) begin
         $display("FAIL cycle_budget cyc=%0d limit=%0d", k, N);
         $fatal(1);
      end
      rst_a[k] = r; en_a[k] = e; x_a[k] = xi; y_a[k] = yi;
      hs_a[k] = h; vs_a[k] = v; run_a[k] = rn;
      reset = r; enable = e; x = xi; y = yi; hsync = h; vsync = v; run = rn;
   endtask

   task automatic idle(input int n, input bit rn);
      int k;
      for (int i = 0; i < n; i++) drv(1, 0, 0, 0, 1, 1, rn, k);
   endtask

   task automatic pix(input int xi, input int yi, input bit e, input int exp_rgb);
      int k;
      drv(1, e, xi, yi, 1, 1, 1, k);
      pin_v[k] = 1; pin_rgb[k] = 12'(exp_rgb);
   endtask

   // One frame: random pixels, then a 6-cycle vsync pulse in blanking
   task automatic frame(input bit rn, input int npix, output int ke);
      int k, xi, yi;
      bit e, h;
      for (int i = 0; i < npix; i++) begin
         e = ($urandom_range(0, 4) != 0);
         h = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            xi = mbx + int'($urandom_range(0, 39)) - 4;
            yi = mby + int'($urandom_range(0, 39)) - 4;
         end else begin
            xi = int'($urandom_range(0, 659)) - 10;
            yi = int'($urandom_range(0, 499)) - 10;
         end
         drv(1, e, xi, yi, h, 1, rn, k);
      end
      drv(1, 0, 0, 0, 1, 0, rn, ke);
      for (int i = 0; i < 5; i++) drv(1, 0, 0, 0, 1, 0, rn, k);
      for (int i = 0; i < 2; i++) drv(1, 0, 0, 0, 1, 1, rn, k);
   endtask

   initial begin
      int k, ke;
      rst_a[0] = 0; vs_a[0] = 1; hs_a[0] = 1;
      rst_a[1] = 0; en_a[1] = 0; x_a[1] = 0; y_a[1] = 0;
      hs_a[1] = 1; vs_a[1] = 1; run_a[1] = 1;
      reset = 0; enable = 0; x = 0; y = 0; hsync = 1; vsync = 1; run = 1;
      drv(0, 0, 0, 0, 1, 1, 1, k);
      drv(0, 0, 0, 0, 1, 1, 1, k);
      pin_v[k] = 1; pin_rgb[k] = 12'h000;
      idle(2, 1);

      // Reset position (100,60), colour F00
      pix(110, 70, 1, 12'hF00);
      pix(99, 70, 1, 12'h003);
      pix(0, 70, 1, 12'hFFF);
      pix(110, 70, 0, 12'h000);
      pix(100, 60, 1, 12'hF00);
      pix(700, 70, 1, 12'h000);

      // hsync pattern 1,0,0,1
      drv(1, 0, 0, 0, 1, 1, 1, k);
      drv(1, 0, 0, 0, 0, 1, 1, k);
      drv(1, 0, 0, 0, 0, 1, 1, k);
      drv(1, 0, 0, 0, 1, 1, 1, k);
      idle(3, 1);

      // Single frame edge: box to (102,62), colour unchanged
      frame(1, 0, ke);
      tpin_v[ke + 3] = 1;
      pix(102, 62, 1, 12'hF00);
      pix(101, 62, 1, 12'h003);
      pix(133, 93, 1, 12'hF00);
      pix(134, 62, 1, 12'h003);

      // vsync pattern 1,0,0,1 (also a frame edge)
      drv(1, 0, 0, 0, 1, 1, 1, k);
      drv(1, 0, 0, 0, 1, 0, 1, k);
      drv(1, 0, 0, 0, 1, 0, 1, k);
      drv(1, 0, 0, 0, 1, 1, 1, k);
      idle(6, 1);
      pix(104, 64, 1, 12'hF00);

      // Run long enough for both Y and X wall bounces
      for (int f = 0; f < 262; f++) frame(1, 4, ke);

      // Frozen: ticks still pulse, box held
      for (int f = 0; f < 5; f++) begin
         frame(0, 6, ke);
         tpin_v[ke + 3] = 1;
      end

      // Reset landing on the UPDATE_Y cycle
      drv(1, 0, 0, 0, 1, 0, 1, ke);
      drv(1, 0, 0, 0, 1, 0, 1, k);
      drv(1, 0, 0, 0, 1, 0, 1, k);
      drv(0, 0, 0, 0, 1, 1, 1, k);
      idle(4, 1);
      pix(100, 60, 1, 12'hF00);
      pix(99, 60, 1, 12'h003);
      pix(131, 91, 1, 12'hF00);

      for (int f = 0; f < 120; f++) frame(1'($urandom_range(0, 3) != 0), 8, ke);

      idle(6, 1);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #(N * 40);
      $display("FAIL timeout cyc=%0d limit=%0d", cyc, N);
      $fatal(1);
   end

endmodule
